// File: rtl/multicycle_ctrl.sv
// rtl/multicycle_ctrl.sv - multi-cycle RV32I main control FSM with retired-instruction counter
module multicycle_ctrl #(
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [6:0]           Op,
  input  logic [2:0]           Funct3,
  input  logic                 Funct7b5,
  input  logic                 Zero,
  input  logic                 MemReady,
  output logic                 PCWrite,
  output logic                 AdrSrc,
  output logic                 MemWrite,
  output logic                 IRWrite,
  output logic [1:0]           ResultSrc,
  output logic [1:0]           ALUSrcA,
  output logic [1:0]           ALUSrcB,
  output logic [2:0]           ALUControl,
  output logic [1:0]           ImmSrc,
  output logic                 RegWrite,
  output logic                 Illegal,
  output logic [CNT_WIDTH-1:0] InstrRetired
);

  localparam logic [6:0] OP_LW = 7'b0000011;
  localparam logic [6:0] OP_SW = 7'b0100011;
  localparam logic [6:0] OP_R  = 7'b0110011;
  localparam logic [6:0] OP_I  = 7'b0010011;
  localparam logic [6:0] OP_BR = 7'b1100011;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTER = 4'd6,
    S_EXECUTEI = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9
  } state_t;

  state_t               state_q, state_d;
  logic [CNT_WIDTH-1:0] retired_q, retired_d;
  logic                 pcw_c, irw_c, memw_c, regw_c, ill_c, retire_c;
  logic                 alu_ok;
  logic [2:0]           alu_op;

  always_comb begin
    state_d    = state_q;
    pcw_c      = 1'b0;
    irw_c      = 1'b0;
    memw_c     = 1'b0;
    regw_c     = 1'b0;
    ill_c      = 1'b0;
    retire_c   = 1'b0;
    AdrSrc     = 1'b0;
    ResultSrc  = 2'b00;
    ALUSrcA    = 2'b00;
    ALUSrcB    = 2'b00;
    ALUControl = 3'b000;
    ImmSrc     = 2'b00;
    alu_ok     = 1'b1;
    alu_op     = 3'b000;

    // Funct3 decode shared by register and immediate ALU ops; Funct7b5 only matters for R-type
    case (Funct3)
      3'b000:  alu_op = Funct7b5 ? 3'b001 : 3'b000;
      3'b010:  alu_op = 3'b101;
      3'b110:  alu_op = 3'b011;
      3'b111:  alu_op = 3'b010;
      default: alu_ok = 1'b0;
    endcase

    case (state_q)
      S_FETCH: begin
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        if (MemReady) begin
          irw_c   = 1'b1;
          pcw_c   = 1'b1;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
        ImmSrc  = 2'b10;
        case (Op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_R:         state_d = S_EXECUTER;
          OP_I:         state_d = S_EXECUTEI;
          OP_BR:        state_d = S_BRANCH;
          default: begin
            ill_c   = 1'b1;
            state_d = S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        ImmSrc  = (Op == OP_SW) ? 2'b01 : 2'b00;
        state_d = (Op == OP_SW) ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        AdrSrc = 1'b1;
        if (MemReady) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        ResultSrc = 2'b01;
        regw_c    = 1'b1;
        retire_c  = 1'b1;
        state_d   = S_FETCH;
      end
      S_MEMWRITE: begin
        AdrSrc = 1'b1;
        memw_c = 1'b1;
        if (MemReady) begin
          retire_c = 1'b1;
          state_d  = S_FETCH;
        end
      end
      S_EXECUTER, S_EXECUTEI: begin
        ALUSrcA = 2'b10;
        ALUSrcB = (state_q == S_EXECUTEI) ? 2'b01 : 2'b00;
        if (alu_ok) begin
          ALUControl = (state_q == S_EXECUTEI && Funct3 == 3'b000) ? 3'b000 : alu_op;
          state_d    = S_ALUWB;
        end else begin
          ill_c   = 1'b1;
          state_d = S_FETCH;
        end
      end
      S_ALUWB: begin
        regw_c   = 1'b1;
        retire_c = 1'b1;
        state_d  = S_FETCH;
      end
      S_BRANCH: begin
        ALUSrcA    = 2'b10;
        ALUControl = 3'b001;
        ImmSrc     = 2'b10;
        state_d    = S_FETCH;
        if (Funct3 == 3'b000)      pcw_c = Zero;
        else if (Funct3 == 3'b001) pcw_c = ~Zero;
        else                       ill_c = 1'b1;
        retire_c = ~ill_c;
      end
      default: state_d = S_FETCH;
    endcase
  end

  assign retired_d = retired_q + {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_FETCH;
      retired_q <= '0;
    end else begin
      state_q <= state_d;
      if (retire_c) retired_q <= retired_d;
    end
  end

  // Reset must kill every strobe combinationally, even before any clock edge
  assign PCWrite      = pcw_c  & ~rst;
  assign IRWrite      = irw_c  & ~rst;
  assign MemWrite     = memw_c & ~rst;
  assign RegWrite     = regw_c & ~rst;
  assign Illegal      = ill_c  & ~rst;
  assign InstrRetired = retired_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb/tb_multicycle_ctrl.sv - randomized self-checking bench for multicycle_ctrl
module tb_multicycle_ctrl;

  localparam logic [6:0] OP_LW = 7'b0000011;
  localparam logic [6:0] OP_SW = 7'b0100011;
  localparam logic [6:0] OP_R  = 7'b0110011;
  localparam logic [6:0] OP_I  = 7'b0010011;
  localparam logic [6:0] OP_BR = 7'b1100011;

  logic        clk = 1'b0;
  logic        rst;
  logic [6:0]  Op;
  logic [2:0]  Funct3;
  logic        Funct7b5, Zero, MemReady;
  logic        PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, Illegal;
  logic [1:0]  ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
  logic [2:0]  ALUControl;
  logic [31:0] InstrRetired;

  multicycle_ctrl #(.CNT_WIDTH(32)) dut (
    .clk(clk), .rst(rst), .Op(Op), .Funct3(Funct3), .Funct7b5(Funct7b5),
    .Zero(Zero), .MemReady(MemReady), .PCWrite(PCWrite), .AdrSrc(AdrSrc),
    .MemWrite(MemWrite), .IRWrite(IRWrite), .ResultSrc(ResultSrc),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUControl(ALUControl),
    .ImmSrc(ImmSrc), .RegWrite(RegWrite), .Illegal(Illegal),
    .InstrRetired(InstrRetired)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       pcw, adr, memw, irw;
    logic [1:0] res, srca, srcb;
    logic [2:0] alu;
    logic [1:0] imm;
    logic       regw, ill;
  } ctl_t;

  ctl_t        got;
  int          checks = 0;
  int          failures = 0;
  logic [31:0] exp_cnt = 0;

  assign got = {PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
                ALUControl, ImmSrc, RegWrite, Illegal};

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive MemReady, compare at the falling edge, then advance past the next rising edge
  task automatic step(input string tag, input ctl_t e, input logic mr);
    MemReady = mr;
    @(negedge clk);
    check_eq(tag, {15'b0, got}, {15'b0, e});
    check_eq({tag, "_cnt"}, InstrRetired, exp_cnt);
    @(posedge clk);
    #1;
  endtask

  // {legal, ALUControl} from the instruction's funct3 rules
  function automatic logic [3:0] ref_alu(input logic [2:0] f3, input logic f7, input logic use_f7);
    case (f3)
      3'd0:    return (use_f7 && f7) ? 4'b1001 : 4'b1000;
      3'd2:    return 4'b1101;
      3'd6:    return 4'b1011;
      3'd7:    return 4'b1010;
      default: return 4'b0000;
    endcase
  endfunction

  task automatic run_instr(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                           input logic z, input int fstall, input int mstall);
    ctl_t       e;
    logic       mr;
    logic [3:0] a;
    logic       known;
    Op = op; Funct3 = f3; Funct7b5 = f7; Zero = z;
    for (int i = 0; i <= fstall; i++) begin
      mr = (i == fstall);
      e = '0; e.srcb = 2'b10; e.res = 2'b10; e.pcw = mr; e.irw = mr;
      step("fetch", e, mr);
    end
    known = (op == OP_LW) || (op == OP_SW) || (op == OP_R) || (op == OP_I) || (op == OP_BR);
    e = '0; e.srca = 2'b01; e.srcb = 2'b01; e.imm = 2'b10; e.ill = ~known;
    step("decode", e, 1'($urandom));
    if (!known) return;
    if (op == OP_LW || op == OP_SW) begin
      e = '0; e.srca = 2'b10; e.srcb = 2'b01; e.imm = (op == OP_SW) ? 2'b01 : 2'b00;
      step("memadr", e, 1'($urandom));
      for (int i = 0; i <= mstall; i++) begin
        mr = (i == mstall);
        e = '0; e.adr = 1'b1; e.memw = (op == OP_SW);
        step((op == OP_SW) ? "memwrite" : "memread", e, mr);
      end
      if (op == OP_LW) begin
        e = '0; e.res = 2'b01; e.regw = 1'b1;
        step("memwb", e, 1'($urandom));
      end
      exp_cnt++;
    end else if (op == OP_R || op == OP_I) begin
      a = ref_alu(f3, f7, op == OP_R);
      e = '0; e.srca = 2'b10; e.srcb = (op == OP_I) ? 2'b01 : 2'b00;
      e.alu = a[2:0]; e.ill = ~a[3];
      step((op == OP_R) ? "execr" : "execi", e, 1'($urandom));
      if (a[3]) begin
        e = '0; e.regw = 1'b1;
        step("aluwb", e, 1'($urandom));
        exp_cnt++;
      end
    end else begin
      e = '0; e.srca = 2'b10; e.alu = 3'b001; e.imm = 2'b10;
      e.ill = (f3 > 3'd1);
      e.pcw = (f3 == 3'd0) ? z : ((f3 == 3'd1) ? ~z : 1'b0);
      step("branch", e, 1'($urandom));
      if (f3 <= 3'd1) exp_cnt++;
    end
  endtask

  function automatic ctl_t fetch_idle();
    ctl_t e;
    e = '0; e.srcb = 2'b10; e.res = 2'b10;
    return e;
  endfunction

  initial begin
    logic [6:0] rop;
    ctl_t       e;
    rst = 1'b1; MemReady = 1'b1; Op = OP_LW; Funct3 = 3'd0; Funct7b5 = 1'b0; Zero = 1'b0;
    #3;
    check_eq("rst_ctl", {15'b0, got}, {15'b0, fetch_idle()});
    check_eq("rst_cnt", InstrRetired, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    MemReady = 1'b0;
    rst = 1'b0;
    @(posedge clk);
    #1;

    run_instr(OP_LW, 3'd2, 1'b0, 1'b0, 0, 0);
    run_instr(OP_SW, 3'd2, 1'b0, 1'b0, 0, 2);
    run_instr(OP_BR, 3'd0, 1'b0, 1'b1, 0, 0);
    run_instr(OP_BR, 3'd1, 1'b0, 1'b1, 0, 0);
    run_instr(OP_R,  3'd0, 1'b1, 1'b0, 0, 0);
    run_instr(OP_I,  3'd0, 1'b1, 1'b0, 0, 0);
    run_instr(OP_I,  3'd6, 1'b0, 1'b0, 3, 0);
    run_instr(7'b1111111, 3'd0, 1'b0, 1'b0, 0, 0);
    run_instr(OP_R,  3'd1, 1'b0, 1'b0, 0, 0);
    run_instr(OP_BR, 3'd4, 1'b0, 1'b0, 0, 0);

    for (int n = 0; n < 300; n++) begin
      case ($urandom_range(0, 5))
        0: rop = OP_LW;
        1: rop = OP_SW;
        2: rop = OP_R;
        3: rop = OP_I;
        4: rop = OP_BR;
        default: rop = 7'($urandom);
      endcase
      run_instr(rop, 3'($urandom), 1'($urandom), 1'($urandom),
                $urandom_range(0, 2), $urandom_range(0, 2));
    end

    // Reset in the middle of a stalled store
    Op = OP_SW;
    e = '0; e.srcb = 2'b10; e.res = 2'b10; e.pcw = 1'b1; e.irw = 1'b1;
    step("pre_fetch", e, 1'b1);
    e = '0; e.srca = 2'b01; e.srcb = 2'b01; e.imm = 2'b10;
    step("pre_decode", e, 1'b0);
    e = '0; e.srca = 2'b10; e.srcb = 2'b01; e.imm = 2'b01;
    step("pre_memadr", e, 1'b0);
    MemReady = 1'b0;
    @(negedge clk);
    check_eq("mw_before_rst", {31'b0, MemWrite}, 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check_eq("mw_in_rst", {31'b0, MemWrite}, 32'd0);
    check_eq("cnt_in_rst", InstrRetired, 32'd0);
    check_eq("ctl_in_rst", {15'b0, got}, {15'b0, fetch_idle()});
    exp_cnt = 0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    step("post_rst_fetch", fetch_idle(), 1'b0);
    run_instr(OP_R, 3'd7, 1'b0, 1'b0, 0, 0);
    run_instr(OP_LW, 3'd2, 1'b0, 1'b0, 1, 1);
    @(negedge clk);
    check_eq("final_cnt", InstrRetired, exp_cnt);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
